// File: rtl/avs_sdram_responder.sv
// Avalon-MM slave memory responder: word-addressed RAM with programmable wait states,
// byte enables and transfer counters. Optional range checking via AVS_SDRAM_RANGE_CHECK_EN.
module avs_sdram_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    csi_clock_clk,
  input  logic                    csi_clock_reset_n,
  input  logic [ADDR_WIDTH-1:0]   avs_s0_address,
  input  logic                    avs_s0_read,
  input  logic                    avs_s0_write,
  input  logic [DATA_WIDTH/8-1:0] avs_s0_byteenable,
  input  logic [DATA_WIDTH-1:0]   avs_s0_writedata,
  output logic                    avs_s0_waitrequest,
  output logic [DATA_WIDTH-1:0]   avs_s0_readdata,
  output logic [CNT_WIDTH-1:0]    stat_reads,
  output logic [CNT_WIDTH-1:0]    stat_writes,
  output logic                    err_flag,
  input  logic                    err_clr
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int BYTE_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WORD_BITS = $clog2(MEM_WORDS);
  localparam int IDX_W     = ADDR_WIDTH - BYTE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  req;
  logic                  out_of_range;
  logic [IDX_W-1:0]      word_idx;
  logic [WORD_BITS-1:0]  ram_addr;
  logic                  issue_read;
  logic                  commit_write;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign req      = avs_s0_read | avs_s0_write;
  assign word_idx = avs_s0_address[ADDR_WIDTH-1:BYTE_BITS];
  assign ram_addr = word_idx[WORD_BITS-1:0];

  // Stall every request until the ACK cycle; also stall while reset is held.
  assign avs_s0_waitrequest = ~csi_clock_reset_n | (req & (state != ST_ACK));

  // Read wins over a simultaneous write, so a write only commits when read is low.
  assign issue_read   = (state == ST_WAIT) && (cnt == 4'd0) && avs_s0_read;
  assign commit_write = (state == ST_ACK) && avs_s0_write && !avs_s0_read && !out_of_range;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      stat_reads  <= '0;
      stat_writes <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_WAIT;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          if (avs_s0_read) begin
            stat_reads <= stat_reads + 1'b1;
          end else if (avs_s0_write) begin
            stat_writes <= stat_writes + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; only control state resets.
  always_ff @(posedge csi_clock_clk) begin
    if (commit_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (avs_s0_byteenable[b]) begin
          mem[ram_addr][b*8 +: 8] <= avs_s0_writedata[b*8 +: 8];
        end
      end
    end
  end

`ifdef AVS_SDRAM_RANGE_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] OOR_PATTERN = {DATA_WIDTH/32{32'hDEADBEEF}};

  assign out_of_range = |word_idx[IDX_W-1:WORD_BITS];

  // A fresh error outranks a clear arriving on the same edge.
  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) begin
      err_flag <= 1'b0;
    end else if ((state == ST_ACK) && req && out_of_range) begin
      err_flag <= 1'b1;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end

  // Registered RAM output doubles as the read-data register; it holds between reads.
  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) begin
      avs_s0_readdata <= '0;
    end else if (issue_read) begin
      avs_s0_readdata <= out_of_range ? OOR_PATTERN : mem[ram_addr];
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, avs_s0_address[BYTE_BITS-1:0]};
`else
  assign out_of_range = 1'b0;
  assign err_flag     = 1'b0;

  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) begin
      avs_s0_readdata <= '0;
    end else if (issue_read) begin
      avs_s0_readdata <= mem[ram_addr];
    end
  end

  // Upper index bits wrap away and err_clr has nothing to clear in this build.
  logic unused_ok;
  assign unused_ok = &{1'b0, err_clr, word_idx[IDX_W-1:WORD_BITS],
                       avs_s0_address[BYTE_BITS-1:0]};
`endif

endmodule

// File: tb/tb_avs_sdram_responder.sv
// Directed self-checking bench for avs_sdram_responder (WAIT_CYCLES=2, CNT_WIDTH=4),
// expectations follow AVS_SDRAM_RANGE_CHECK_EN when defined.
module tb_avs_sdram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [3:0]  stat_reads;
  logic [3:0]  stat_writes;
  logic        err_flag;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  avs_sdram_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_WORDS  (1024),
    .WAIT_CYCLES(2),
    .CNT_WIDTH  (4)
  ) dut (
    .csi_clock_clk     (clk),
    .csi_clock_reset_n (rst_n),
    .avs_s0_address    (address),
    .avs_s0_read       (read),
    .avs_s0_write      (write),
    .avs_s0_byteenable (byteenable),
    .avs_s0_writedata  (writedata),
    .avs_s0_waitrequest(waitrequest),
    .avs_s0_readdata   (readdata),
    .stat_reads        (stat_reads),
    .stat_writes       (stat_writes),
    .err_flag          (err_flag),
    .err_clr           (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request at a negedge and returns in the ACK cycle, before the ACK edge.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rdata, output int cycles);
    @(negedge clk);
    read = rd; write = wr; address = addr; byteenable = be; writedata = wd;
    cycles = 0;
    rdata  = 'x;
    forever begin
      #1;
      cycles++;
      if (!waitrequest) begin
        rdata = readdata;
        break;
      end
      if (cycles >= 40) begin
        checks++;
        failures++;
        $display("FAIL xfer_timeout: got no ACK after %0d cycles required 5", cycles);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    read = 1'b0; write = 1'b0; err_clr = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h111;
  endfunction

  initial begin
    logic [31:0] rdata;
    int          cyc;
    int          total;

    rst_n = 1'b0; read = 1'b1; write = 1'b0; address = 32'h0;
    byteenable = 4'h0; writedata = 32'h0; err_clr = 1'b0;

    // Reset with a read pending
    repeat (2) @(negedge clk);
    #1;
    check("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
    check("rst_readdata", readdata, 32'h0);
    check("rst_stat_reads", {28'd0, stat_reads}, 32'd0);
    check("rst_stat_writes", {28'd0, stat_writes}, 32'd0);
    check("rst_err_flag", {31'd0, err_flag}, 32'd0);
    @(negedge clk);
    read = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_waitrequest", {31'd0, waitrequest}, 32'd0);

    // Single full-word write
    xfer(1'b0, 1'b1, 32'h10, 4'hF, 32'h12345678, rdata, cyc);
    wr_cnt++;
    check("wr_wait_cycles", 32'(cyc - 1), 32'd4);
    go_idle();
    check("wr_stat_writes", {28'd0, stat_writes}, 32'(wr_cnt % 16));

    // Byte-enable merge
    xfer(1'b0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, rdata, cyc);
    wr_cnt++;
    go_idle();
    xfer(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdata, cyc);
    rd_cnt++;
    check("be_readdata", rdata, 32'h12BB56DD);
    check("rd_total_cycles", 32'(cyc), 32'd5);
    go_idle();
    check("be_stat_reads", {28'd0, stat_reads}, 32'(rd_cnt % 16));

    // Read and write together: read served, write ignored
    xfer(1'b1, 1'b1, 32'h10, 4'hF, 32'h0, rdata, cyc);
    rd_cnt++;
    check("rw_readdata", rdata, 32'h12BB56DD);
    go_idle();
    check("rw_stat_writes", {28'd0, stat_writes}, 32'(wr_cnt % 16));
    xfer(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdata, cyc);
    rd_cnt++;
    check("rw_no_commit", rdata, 32'h12BB56DD);
    go_idle();

    // Abort: read dropped after one WAIT cycle
    @(negedge clk);
    read = 1'b1; address = 32'h10;
    @(negedge clk);
    #1;
    check("abort_in_wait", {31'd0, waitrequest}, 32'd1);
    read = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_stat_reads", {28'd0, stat_reads}, 32'(rd_cnt % 16));
    check("abort_waitrequest", {31'd0, waitrequest}, 32'd0);
    xfer(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdata, cyc);
    rd_cnt++;
    check("abort_then_idle_cycles", 32'(cyc), 32'd5);
    go_idle();

    // Back-to-back writes then reads, no idle gap
    total = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 1'b1, 32'(i * 4), 4'hF, pat(i), rdata, cyc);
      total += cyc;
      wr_cnt++;
    end
    go_idle();
    check("b2b_write_cycles", 32'(total), 32'd40);
    check("b2b_stat_writes", {28'd0, stat_writes}, 32'(wr_cnt % 16));
    total = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 1'b0, 32'(i * 4), 4'hF, 32'h0, rdata, cyc);
      total += cyc;
      rd_cnt++;
      check($sformatf("b2b_read_%0d", i), rdata, pat(i));
    end
    go_idle();
    check("b2b_read_cycles", 32'(total), 32'd40);
    check("b2b_stat_reads", {28'd0, stat_reads}, 32'(rd_cnt % 16));

    // Out-of-range read
    xfer(1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, rdata, cyc);
    rd_cnt++;
`ifdef AVS_SDRAM_RANGE_CHECK_EN
    check("oor_readdata", rdata, 32'hDEADBEEF);
    go_idle();
    check("oor_err_set", {31'd0, err_flag}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("oor_err_clr", {31'd0, err_flag}, 32'd0);
`else
    check("wrap_readdata", rdata, pat(0));
    go_idle();
    check("wrap_err_flag", {31'd0, err_flag}, 32'd0);
`endif

    // Clear and new error on the same edge: error wins
    @(negedge clk);
    err_clr = 1'b1;
    xfer(1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, rdata, cyc);
    rd_cnt++;
    go_idle();
`ifdef AVS_SDRAM_RANGE_CHECK_EN
    check("err_wins_over_clr", {31'd0, err_flag}, 32'd1);
`else
    check("err_tied_low", {31'd0, err_flag}, 32'd0);
`endif

    // Out-of-range write: dropped with the check, aliases word 0 without it
    xfer(1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, rdata, cyc);
    wr_cnt++;
    go_idle();
    check("oor_wr_stat_writes", {28'd0, stat_writes}, 32'(wr_cnt % 16));
    xfer(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, rdata, cyc);
    rd_cnt++;
`ifdef AVS_SDRAM_RANGE_CHECK_EN
    check("oor_wr_dropped", rdata, pat(0));
`else
    check("oor_wr_wraps", rdata, 32'hFFFFFFFF);
`endif
    go_idle();

    // Counter wrap: two more reads bring the total to 17
    for (int i = 0; i < 2; i++) begin
      xfer(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdata, cyc);
      rd_cnt++;
    end
    go_idle();
    check("wrap_total_reads", 32'(rd_cnt), 32'd17);
    check("wrap_stat_reads", {28'd0, stat_reads}, 32'd1);

    // Reset mid-transfer: pending write must not commit
    xfer(1'b0, 1'b1, 32'h20, 4'hF, 32'h600DF00D, rdata, cyc);
    go_idle();
    @(negedge clk);
    write = 1'b1; address = 32'h20; byteenable = 4'hF; writedata = 32'hBAD0BAD0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    write = 1'b0;
    #1;
    check("midrst_waitrequest", {31'd0, waitrequest}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_stat_writes", {28'd0, stat_writes}, 32'd0);
    check("midrst_stat_reads", {28'd0, stat_reads}, 32'd0);
    xfer(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, rdata, cyc);
    check("midrst_no_commit", rdata, 32'h600DF00D);
    go_idle();
    check("midrst_read_counted", {28'd0, stat_reads}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
